// File: rtl/rv32_enc_pkg.sv
// rv32_enc_pkg: instruction classes, RV32I opcodes, NOP word and immediate range limits
package rv32_enc_pkg;
    typedef enum logic [3:0] {
        CL_LOAD   = 4'd0,
        CL_STORE  = 4'd1,
        CL_RTYPE  = 4'd2,
        CL_ITYPE  = 4'd3,
        CL_BRANCH = 4'd4,
        CL_JAL    = 4'd5,
        CL_JALR   = 4'd6,
        CL_LUI    = 4'd7,
        CL_AUIPC  = 4'd8
    } cls_e;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int I_MIN = -2048;
    localparam int I_MAX = 2047;
    localparam int B_MIN = -4096;
    localparam int B_MAX = 4094;
    localparam int J_MIN = -1048576;
    localparam int J_MAX = 1048574;
endpackage

// File: rtl/enc_fifo2.sv
// enc_fifo2: 2-entry valid/ready FIFO; ports clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data
module enc_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] m0, m1;
    logic rp, wp, push, pop;
    logic [1:0] cnt;
    assign in_ready  = cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = rp ? m1 : m0;
    always_ff @(posedge clk) begin
        if (rst) begin
            m0  <= '0;
            m1  <= '0;
            rp  <= 1'b0;
            wp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push && wp) m1 <= in_data;
            if (push && !wp) m0 <= in_data;
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: packs field-level RV32I requests into words tagged with sequential addresses
// Ports: clk, rst; req_* request handshake and fields; addr_load/addr_load_val counter load;
// out_valid/out_ready/out_instr/out_addr/out_err buffered output. Optional: ENCODER_RANGE_CHECK_EN.
module rv32_instr_encoder
    import rv32_enc_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_class,
    input  logic [2:0]        req_funct3,
    input  logic              req_f7b5,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_load_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);
    // Returns {err, word}
    function automatic logic [32:0] encode(logic [3:0] c, logic [2:0] f3, logic f7b5,
                                           logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                           logic [31:0] imm);
        logic [6:0] f7;
        f7 = {1'b0, f7b5, 5'b0};
        case (c)
            CL_LOAD:   return {1'b0, imm[11:0], rs1, f3, rd, OP_LOAD};
            CL_STORE:  return {1'b0, imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            CL_RTYPE:  return {1'b0, f7, rs2, rs1, f3, rd, OP_RTYPE};
            CL_ITYPE:  return (f3 == 3'b001 || f3 == 3'b101)
                              ? {1'b0, f7, imm[4:0], rs1, f3, rd, OP_ITYPE}
                              : {1'b0, imm[11:0], rs1, f3, rd, OP_ITYPE};
            CL_BRANCH: return {1'b0, imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            CL_JAL:    return {1'b0, imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            CL_JALR:   return {1'b0, imm[11:0], rs1, 3'b000, rd, OP_JALR};
            CL_LUI:    return {1'b0, imm[31:12], rd, OP_LUI};
            CL_AUIPC:  return {1'b0, imm[31:12], rd, OP_AUIPC};
            default:   return {1'b1, NOP};
        endcase
    endfunction
    logic [32:0] raw, enc;
    logic [ADDR_W-1:0] ctr, tag;
    logic [32+ADDR_W:0] od;
    logic acc;
    assign raw = encode(req_class, req_funct3, req_f7b5, req_rd, req_rs1, req_rs2, req_imm);
`ifdef ENCODER_RANGE_CHECK_EN
    function automatic logic imm_ok(logic [3:0] c, logic [2:0] f3, logic [31:0] imm);
        int s;
        s = imm;
        case (c)
            CL_LOAD, CL_STORE, CL_JALR: return s >= I_MIN && s <= I_MAX;
            CL_ITYPE:  return (f3 == 3'b001 || f3 == 3'b101) ? imm < 32'd32 : s >= I_MIN && s <= I_MAX;
            CL_BRANCH: return s >= B_MIN && s <= B_MAX && !imm[0];
            CL_JAL:    return s >= J_MIN && s <= J_MAX && !imm[0];
            CL_LUI, CL_AUIPC: return imm[11:0] == 12'd0;
            default:   return 1'b1;
        endcase
    endfunction
    assign enc = imm_ok(req_class, req_funct3, req_imm) ? raw : {1'b1, NOP};
`else
    assign enc = raw;
`endif
    assign acc = req_valid && req_ready;
    // A same-cycle load retags the accepted request too
    assign tag = addr_load ? addr_load_val : ctr;
    always_ff @(posedge clk) begin
        if (rst) ctr <= BASE_ADDR;
        else if (addr_load || acc) ctr <= tag + (acc ? ADDR_W'(4) : '0);
    end
    enc_fifo2 #(.W(33 + ADDR_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (req_valid),
        .in_ready  (req_ready),
        .in_data   ({enc[31:0], tag, enc[32]}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (od)
    );
    assign {out_instr, out_addr, out_err} = od;
endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb_rv32_instr_encoder: table-driven and sequence checks of rv32_instr_encoder
module tb_rv32_instr_encoder;
    logic clk = 1'b0, rst, req_valid, req_ready, req_f7b5, addr_load, out_valid, out_ready, out_err;
    logic [3:0] req_class;
    logic [2:0] req_funct3;
    logic [4:0] req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm, addr_load_val, out_instr, out_addr;
    int total = 0, bad = 0;
    typedef struct {
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, ei;
        logic        ee;
    } vec_t;
    vec_t v[13];
    always #5 clk = ~clk;
    rv32_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_funct3(req_funct3), .req_f7b5(req_f7b5),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err)
    );
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask
    task automatic set_req(input vec_t x);
        req_class = x.cls; req_funct3 = x.f3; req_f7b5 = x.f7;
        req_rd = x.rd; req_rs1 = x.rs1; req_rs2 = x.rs2; req_imm = x.imm;
    endtask
    function automatic vec_t itv(input logic [31:0] k);
        return '{4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, k, (k << 20) | 32'h93, 1'b0};
    endfunction
    initial begin
        logic [31:0] ea;
        v[0]  = '{4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093, 1'b0};
        v[1]  = '{4'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b0};
        v[2]  = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd4,       32'hFE000EE3, 1'b0};
        v[3]  = '{4'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3, 1'b0};
        v[4]  = '{4'd3, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,         32'h4030D093, 1'b0};
        v[5]  = '{4'd0, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, -32'sd4,       32'hFFC12283, 1'b0};
        v[6]  = '{4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         32'h008000EF, 1'b0};
        v[7]  = '{4'd6, 3'd3, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,         32'h00008067, 1'b0};
        v[8]  = '{4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1000,      32'h00001097, 1'b0};
        v[9]  = '{4'd12, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00000013, 1'b1};
        v[10] = '{4'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd2,       32'hFFFFF06F, 1'b0};
`ifdef ENCODER_RANGE_CHECK_EN
        v[11] = '{4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096,      32'h00000013, 1'b1};
        v[12] = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3,         32'h00000013, 1'b1};
`else
        v[11] = '{4'd3, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096,      32'h00000093, 1'b0};
        v[12] = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3,         32'h00000163, 1'b0};
`endif
        rst = 1'b1; req_valid = 1'b0; addr_load = 1'b0; addr_load_val = '0; out_ready = 1'b1;
        set_req(v[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk) rst = 1'b0;
        ea = 32'h0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            set_req(v[i]);
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(v[i].ei));
            chk($sformatf("vec%0d_addr", i), 64'(out_addr), 64'(ea));
            chk($sformatf("vec%0d_err", i), 64'(out_err), 64'(v[i].ee));
            ea += 32'd4;
        end
        @(negedge clk);
        set_req('{4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h0, 1'b0});
        addr_load = 1'b1; addr_load_val = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        #1;
        addr_load = 1'b0; req_valid = 1'b0;
        chk("lui_instr", 64'(out_instr), 64'h123452B7);
        chk("lui_addr", 64'(out_addr), 64'h100);
        @(negedge clk);
        set_req(v[0]); req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("after_load_addr", 64'(out_addr), 64'h104);
        chk("after_load_instr", 64'(out_instr), 64'h00500093);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b0; set_req(itv(1)); req_valid = 1'b1;
        @(posedge clk);
        #1 chk("bp_ready1", 64'(req_ready), 64'd1);
        @(negedge clk) set_req(itv(2));
        @(posedge clk);
        #1 chk("bp_ready2", 64'(req_ready), 64'd0);
        @(negedge clk) set_req(itv(3));
        @(posedge clk);
        #1;
        chk("bp_held_ready", 64'(req_ready), 64'd0);
        chk("bp_stable_instr", 64'(out_instr), 64'h00100093);
        chk("bp_stable_addr", 64'(out_addr), 64'h0);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain2_instr", 64'(out_instr), 64'h00200093);
        chk("drain2_addr", 64'(out_addr), 64'h4);
        chk("drain2_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("drain3_instr", 64'(out_instr), 64'h00300093);
        chk("drain3_addr", 64'(out_addr), 64'h8);
        @(negedge clk);
        out_ready = 1'b0; set_req(itv(4));
        repeat (2) @(posedge clk);
        #1 chk("full_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1; addr_load = 1'b1; addr_load_val = 32'h500;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);
        chk("midrst_instr", 64'(out_instr), 64'd0);
        @(negedge clk);
        rst = 1'b0; addr_load = 1'b0; out_ready = 1'b1; set_req(itv(5)); req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("postrst_valid", 64'(out_valid), 64'd1);
        chk("postrst_addr", 64'(out_addr), 64'h0);
        chk("postrst_instr", 64'(out_instr), 64'h00500093);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
